// File: rtl/bus_arbiter_8x3.sv
// Round-robin arbiter for eight requesters sharing one 8:1 mux path.
// Registered one-hot grant plus binary select, with an optional hold-time limit.
module bus_arbiter_8x3 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       valid,
    output logic       preempt
);

    localparam int unsigned N_REQ    = 8;
    localparam logic [7:0]  HOLD_SAT = (MAX_HOLD == 0) ? 8'hFF : 8'(MAX_HOLD - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state,   w_state;
    logic [7:0] r_grant,   w_grant;
    logic [2:0] r_sel,     w_sel;
    logic       r_valid,   w_valid;
    logic       r_preempt, w_preempt;
    logic [2:0] r_ptr,     w_ptr;
    logic [7:0] r_hold,    w_hold;

    logic       w_pick_found;
    logic [2:0] w_pick_idx;
    logic [2:0] w_scan_idx;
    logic       w_timeout;

    // First requester at or above ptr, wrapping modulo 8
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = r_ptr;
        w_scan_idx   = r_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            w_scan_idx = r_ptr + 3'(i);
            if (!w_pick_found && req[w_scan_idx]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_scan_idx;
            end
        end
    end

    assign w_timeout = (MAX_HOLD != 0) && (r_hold == HOLD_SAT) && ((req & ~r_grant) != 8'h00);

    always_comb begin
        w_state   = r_state;
        w_grant   = r_grant;
        w_sel     = r_sel;
        w_valid   = r_valid;
        w_preempt = 1'b0;
        w_ptr     = r_ptr;
        w_hold    = r_hold;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_state = S_GRANT;
                    w_grant = 8'd1 << w_pick_idx;
                    w_sel   = w_pick_idx;
                    w_valid = 1'b1;
                    w_hold  = 8'd0;
                end
            end
            S_GRANT: begin
                // Any release cause ends in the one-cycle IDLE gap; sel keeps the last owner
                if (done || !req[r_sel] || w_timeout) begin
                    w_state   = S_IDLE;
                    w_grant   = 8'h00;
                    w_valid   = 1'b0;
                    w_ptr     = r_sel + 3'd1;
                    w_preempt = w_timeout;
                end else if (r_hold != HOLD_SAT) begin
                    w_hold = r_hold + 8'd1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_grant = 8'h00;
                w_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_grant   <= 8'h00;
            r_sel     <= 3'd0;
            r_valid   <= 1'b0;
            r_preempt <= 1'b0;
            r_ptr     <= 3'd0;
            r_hold    <= 8'd0;
        end else begin
            r_state   <= w_state;
            r_grant   <= w_grant;
            r_sel     <= w_sel;
            r_valid   <= w_valid;
            r_preempt <= w_preempt;
            r_ptr     <= w_ptr;
            r_hold    <= w_hold;
        end
    end

    assign grant   = r_grant;
    assign sel     = r_sel;
    assign valid   = r_valid;
    assign preempt = r_preempt;

endmodule
